// File: rtl/seg_decode_monitor_if.sv
// Seven-segment monitor bus: sampled display/timeout inputs plus decoded count and event outputs.
interface seg_decode_monitor_if #(
  parameter int TO_CNT_W = 8
);
  logic [6:0]          seg;
  logic                timeout;
  logic                clr;
  logic [2:0]          digit;
  logic                digit_valid;
  logic                bad_pat;
  logic                chg;
  logic                step_up;
  logic                step_down;
  logic                step_wrap;
  logic                step_jump;
  logic                to_pulse;
  logic [TO_CNT_W-1:0] to_count;

  modport master (
    output seg, timeout, clr,
    input  digit, digit_valid, bad_pat, chg, step_up, step_down, step_wrap, step_jump,
           to_pulse, to_count
  );

  modport slave (
    input  seg, timeout, clr,
    output digit, digit_valid, bad_pat, chg, step_up, step_down, step_wrap, step_jump,
           to_pulse, to_count
  );
endinterface

// File: rtl/seg_decode_monitor.sv
// Deglitches a seven-segment bus, decodes it to a 0..7 count and classifies each change; counts timeouts.
// Latency STABLE_CYCLES+1 edges from a held seg change to outputs; no backpressure, every cycle is sampled.
module seg_decode_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int TO_CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  seg_decode_monitor_if.slave bus
);
  localparam logic [6:0] GLYPH_ZERO = 7'h7E;

  logic [6:0]          s_seg;
  logic [6:0]          cand;
  logic [6:0]          acc_pat;
  logic [7:0]          stab_cnt;
  logic [7:0]          stab_nxt;
  logic                s_to;
  logic                s_to_d;
  logic                accept;
  logic                legal;
  logic [2:0]          dec;
  logic                up_c;
  logic                down_c;
  logic                wrap_c;
  logic                jump_c;
  logic [2:0]          digit;
  logic                digit_valid;
  logic                bad_pat;
  logic                chg;
  logic                step_up;
  logic                step_down;
  logic                step_wrap;
  logic                step_jump;
  logic                to_pulse;
  logic [TO_CNT_W-1:0] to_count;

  // Returns {legal, value}
  function automatic logic [3:0] decode(input logic [6:0] p);
    case (p)
      7'h7E:   decode = 4'b1_000;
      7'h30:   decode = 4'b1_001;
      7'h6D:   decode = 4'b1_010;
      7'h79:   decode = 4'b1_011;
      7'h33:   decode = 4'b1_100;
      7'h5B:   decode = 4'b1_101;
      7'h5F:   decode = 4'b1_110;
      7'h70:   decode = 4'b1_111;
      default: decode = 4'b0_000;
    endcase
  endfunction

  always_comb begin
    stab_nxt = stab_cnt;
    if (s_seg != cand) begin
      stab_nxt = 8'd0;
    end else if (stab_cnt != 8'hFF) begin
      stab_nxt = stab_cnt + 8'd1;
    end
    // Comparing the new sample (not cand) lets STABLE_CYCLES=1 accept on the first registered sample.
    accept = (stab_nxt >= 8'(STABLE_CYCLES - 1)) && (s_seg != acc_pat);

    {legal, dec} = decode(s_seg);
    up_c   = (dec == digit + 3'd1) && (digit != 3'd7);
    down_c = (dec == digit - 3'd1) && (digit != 3'd0);
    wrap_c = !up_c && !down_c && (dec != digit) && ((digit == 3'd0) || (dec == 3'd0));
    jump_c = !up_c && !down_c && !wrap_c && (dec != digit);
  end

  assign to_pulse = s_to & ~s_to_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg       <= GLYPH_ZERO;
      cand        <= GLYPH_ZERO;
      acc_pat     <= GLYPH_ZERO;
      stab_cnt    <= 8'd0;
      s_to        <= 1'b0;
      s_to_d      <= 1'b0;
      digit       <= 3'd0;
      digit_valid <= 1'b0;
      bad_pat     <= 1'b0;
      chg         <= 1'b0;
      step_up     <= 1'b0;
      step_down   <= 1'b0;
      step_wrap   <= 1'b0;
      step_jump   <= 1'b0;
      to_count    <= '0;
    end else begin
      s_seg     <= bus.seg;
      s_to      <= bus.timeout;
      s_to_d    <= s_to;
      cand      <= s_seg;
      stab_cnt  <= stab_nxt;
      chg       <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      step_wrap <= 1'b0;
      step_jump <= 1'b0;

      if (accept) begin
        acc_pat <= s_seg;
        chg     <= 1'b1;
        if (legal) begin
          digit       <= dec;
          bad_pat     <= 1'b0;
          digit_valid <= 1'b1;
          if (digit_valid) begin
            step_up   <= up_c;
            step_down <= down_c;
            step_wrap <= wrap_c;
            step_jump <= jump_c;
          end
        end else begin
          bad_pat <= 1'b1;
        end
      end

      // clr takes priority over both a same-cycle acceptance and a timeout edge.
      if (bus.clr) begin
        to_count    <= '0;
        digit_valid <= 1'b0;
      end else if (to_pulse && (to_count != {TO_CNT_W{1'b1}})) begin
        to_count <= to_count + 1'b1;
      end
    end
  end

  assign bus.digit       = digit;
  assign bus.digit_valid = digit_valid;
  assign bus.bad_pat     = bad_pat;
  assign bus.chg         = chg;
  assign bus.step_up     = step_up;
  assign bus.step_down   = step_down;
  assign bus.step_wrap   = step_wrap;
  assign bus.step_jump   = step_jump;
  assign bus.to_pulse    = to_pulse;
  assign bus.to_count    = to_count;
endmodule
